// File: rtl/conv_seq_pkg.sv
// Shared state encoding and default constants for the conv1 layer sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } seq_state_t;

  localparam int FILTERS_PER_GROUP = 8;
  localparam int DEF_NUM_GROUPS    = 4;
  localparam int DEF_WGT_STRIDE    = 9;
  localparam int DEF_OMAP_DEPTH    = 676;
  localparam int DEF_WADDR_W       = 7;
  localparam int DEF_OADDR_W       = 12;
  localparam int DEF_TIMEOUT_CYC   = 4096;

  // group_idx is never narrower than one bit, even for a single-group layer
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv1_sequencer_watchdog.sv
// Per-pass watchdog: synchronous clear, count enable, terminal count at TIMEOUT_CYC-1.
module seq_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // parks at the terminal count so a stalled RUN cannot wrap back to zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv1_sequencer.sv
// conv1 layer controller: one engine pass per filter group, with abort and watchdog.
// Optional macro CONV1_SEQ_PERF_EN builds the saturating layer cycle counter.
//
// state | meaning
// IDLE  | waiting for layer_start
// LOAD  | bases settle at the engine ports
// START | conv_start pulse, watchdog cleared
// RUN   | engine busy, watchdog counting
// NEXT  | advance group index and bases
// DONE  | layer_done pulse
// ERR   | watchdog expired, waits for layer_start or abort
module conv1_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_GROUPS  = DEF_NUM_GROUPS,
  parameter int WGT_STRIDE  = DEF_WGT_STRIDE,
  parameter int OMAP_DEPTH  = DEF_OMAP_DEPTH,
  parameter int WADDR_W     = DEF_WADDR_W,
  parameter int OADDR_W     = DEF_OADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             layer_start,
  input  logic                             abort,
  input  logic                             conv_done,
  output logic                             conv_start,
  output logic [idx_width(NUM_GROUPS)-1:0] group_idx,
  output logic [WADDR_W-1:0]               weight_base,
  output logic [OADDR_W-1:0]               omem_base,
  output logic                             layer_busy,
  output logic                             layer_done,
  output logic                             timeout_err,
  output logic [31:0]                      perf_cycles
);

  if (NUM_GROUPS < 1 || NUM_GROUPS > 16) begin : g_bad_groups
    $error("conv1_sequencer: NUM_GROUPS must be within 1..16");
  end
  if ((NUM_GROUPS - 1) * WGT_STRIDE >= 2 ** WADDR_W) begin : g_bad_waddr
    $error("conv1_sequencer: last weight base does not fit WADDR_W");
  end
  if ((NUM_GROUPS - 1) * OMAP_DEPTH >= 2 ** OADDR_W) begin : g_bad_oaddr
    $error("conv1_sequencer: last output base does not fit OADDR_W");
  end

  seq_state_t state_q, state_d;
  logic       wd_tc;
  logic       last_grp;
  logic       start_acc;

  assign last_grp  = (int'(group_idx) == NUM_GROUPS - 1);
  assign start_acc = layer_start && !abort && (state_q == S_IDLE || state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: if (layer_start) state_d = S_LOAD;
        S_LOAD:        state_d = S_START;
        S_START:       state_d = S_RUN;
        S_RUN: begin
          // a done arriving on the terminal-count cycle still completes the pass
          if (conv_done)  state_d = last_grp ? S_DONE : S_NEXT;
          else if (wd_tc) state_d = S_ERR;
        end
        S_NEXT:        state_d = S_LOAD;
        S_DONE:        state_d = S_IDLE;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      group_idx   <= '0;
      weight_base <= '0;
      omem_base   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        group_idx   <= '0;
        weight_base <= '0;
        omem_base   <= '0;
        timeout_err <= 1'b0;
      end else if (state_q == S_NEXT && !abort) begin
        group_idx   <= group_idx + 1'b1;
        weight_base <= weight_base + WADDR_W'(WGT_STRIDE);
        omem_base   <= omem_base + OADDR_W'(OMAP_DEPTH);
      end
      if (state_q == S_RUN && !abort && !conv_done && wd_tc) timeout_err <= 1'b1;
    end
  end

  seq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .resetn(resetn),
    .clr   (state_q == S_START),
    .en    (state_q == S_RUN),
    .tc    (wd_tc)
  );

  assign conv_start = (state_q == S_START);
  assign layer_done = (state_q == S_DONE);
  assign layer_busy = !(state_q == S_IDLE || state_q == S_ERR);

`ifdef CONV1_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (layer_busy && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv1_sequencer.sv
// Bench for conv1_sequencer: cycle table on a single-group build, hand-written
// multi-cycle sequences, and random layer scenarios against a timeline model.
module tb_conv1_sequencer;

  localparam int TO   = 64;
  localparam int NG   = 4;
  localparam int MAXC = 512;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u_a: default build; u_b: single group; u_c: four groups, short watchdog
  logic a_ls, a_ab, a_cd, a_cs, a_busy, a_ld, a_terr;
  logic [1:0]  a_gidx;
  logic [6:0]  a_wb;
  logic [11:0] a_ob;
  logic [31:0] a_perf;
  logic b_ls, b_ab, b_cd, b_cs, b_busy, b_ld, b_terr;
  logic [0:0]  b_gidx;
  logic [6:0]  b_wb;
  logic [11:0] b_ob;
  logic [31:0] b_perf;
  logic c_ls, c_ab, c_cd, c_cs, c_busy, c_ld, c_terr;
  logic [1:0]  c_gidx;
  logic [6:0]  c_wb;
  logic [11:0] c_ob;
  logic [31:0] c_perf;

  conv1_sequencer u_a (
    .clk(clk), .resetn(resetn), .layer_start(a_ls), .abort(a_ab), .conv_done(a_cd),
    .conv_start(a_cs), .group_idx(a_gidx), .weight_base(a_wb), .omem_base(a_ob),
    .layer_busy(a_busy), .layer_done(a_ld), .timeout_err(a_terr), .perf_cycles(a_perf)
  );

  conv1_sequencer #(.NUM_GROUPS(1)) u_b (
    .clk(clk), .resetn(resetn), .layer_start(b_ls), .abort(b_ab), .conv_done(b_cd),
    .conv_start(b_cs), .group_idx(b_gidx), .weight_base(b_wb), .omem_base(b_ob),
    .layer_busy(b_busy), .layer_done(b_ld), .timeout_err(b_terr), .perf_cycles(b_perf)
  );

  conv1_sequencer #(.NUM_GROUPS(NG), .TIMEOUT_CYC(TO)) u_c (
    .clk(clk), .resetn(resetn), .layer_start(c_ls), .abort(c_ab), .conv_done(c_cd),
    .conv_start(c_cs), .group_idx(c_gidx), .weight_base(c_wb), .omem_base(c_ob),
    .layer_busy(c_busy), .layer_done(c_ld), .timeout_err(c_terr), .perf_cycles(c_perf)
  );

  int a_cs_cnt = 0;
  int a_ld_cnt = 0;
  always @(negedge clk) begin
    if (a_cs === 1'b1) a_cs_cnt++;
    if (a_ld === 1'b1) a_ld_cnt++;
  end

  typedef struct packed {
    bit ls, cd, ab;
    bit cs, ld, busy;
  } vec_t;
  vec_t tbl[15];

  // per-cycle stimulus and expectations of one random scenario
  bit drv_ls[MAXC], drv_cd[MAXC], drv_ab[MAXC];
  bit e_cs[MAXC], e_ld[MAXC], e_busy[MAXC], e_terr[MAXC], is_run[MAXC];
  int e_gidx[MAXC];
  int lat[NG];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Timeline of one layer: start in cycle 0, LOAD/START/RUN per group; a pass whose
  // done arrives more than TO cycles into RUN ends in ERR. Abort freezes everything.
  task automatic build_scen(input int abort_at, input bit t0, input int g0, output int len);
    int t, d, rest_from, rest_g, lim;
    bit rest_terr, fin;
    for (int c = 0; c < MAXC; c++) begin
      drv_ls[c] = 0; drv_cd[c] = 0; drv_ab[c] = 0;
      e_cs[c] = 0; e_ld[c] = 0; e_busy[c] = 0; is_run[c] = 0;
      e_terr[c] = (c == 0) ? t0 : 1'b0;
      e_gidx[c] = (c == 0) ? g0 : 0;
    end
    drv_ls[0] = 1;
    t = 1; fin = 0; rest_from = 0; rest_g = 0; rest_terr = 0;
    for (int g = 0; g < NG && !fin; g++) begin
      e_busy[t] = 1;   e_gidx[t] = g;
      e_busy[t+1] = 1; e_gidx[t+1] = g; e_cs[t+1] = 1;
      if (lat[g] <= TO) begin
        d = t + 1 + lat[g];
        for (int c = t + 2; c <= d; c++) begin e_busy[c] = 1; is_run[c] = 1; e_gidx[c] = g; end
        drv_cd[d] = 1;
        e_busy[d+1] = 1; e_gidx[d+1] = g;
        if (g == NG - 1) begin
          e_ld[d+1] = 1; rest_from = d + 2; rest_g = g; fin = 1;
        end else begin
          t = d + 2;
        end
      end else begin
        for (int c = t + 2; c <= t + 1 + TO; c++) begin e_busy[c] = 1; is_run[c] = 1; e_gidx[c] = g; end
        rest_from = t + 2 + TO; rest_g = g; rest_terr = 1; fin = 1;
      end
    end
    len = rest_from + 3;
    for (int c = rest_from; c < len; c++) begin e_gidx[c] = rest_g; e_terr[c] = rest_terr; end
    lim = len;
    if (abort_at > 0 && abort_at < len) begin
      lim = abort_at;
      drv_ab[abort_at] = 1;
      for (int c = abort_at + 1; c < len; c++) begin
        e_busy[c] = 0; e_cs[c] = 0; e_ld[c] = 0;
        e_gidx[c] = e_gidx[abort_at]; e_terr[c] = e_terr[abort_at];
      end
    end
    for (int c = 1; c < len; c++) begin
      if (e_busy[c] && c <= lim && $urandom_range(0, 7) == 0) drv_ls[c] = 1;
      if ((!is_run[c] || c > lim) && $urandom_range(0, 7) == 0) drv_cd[c] = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int len, abort_at, g0, exp_perf, base_cs, base_ld;
    bit t0;

    resetn = 1'b0;
    a_ls = 0; a_ab = 0; a_cd = 0;
    b_ls = 0; b_ab = 0; b_cd = 0;
    c_ls = 0; c_ab = 0; c_cd = 0;
    #2;
    chk("rst_cs", a_cs, 0);     chk("rst_ld", a_ld, 0);
    chk("rst_busy", a_busy, 0); chk("rst_terr", a_terr, 0);
    chk("rst_gidx", a_gidx, 0); chk("rst_wbase", a_wb, 0);
    chk("rst_obase", a_ob, 0);  chk("rst_perf", a_perf, 0);
    #8 resetn = 1'b1;
    step();

    // single group: start at 0, done at 10, plus ignored inputs
    //            ls cd ab  cs ld busy
    tbl[0]  = 6'b100_000;
    tbl[1]  = 6'b010_001;
    tbl[2]  = 6'b000_101;
    tbl[3]  = 6'b100_001;
    for (int i = 4; i < 10; i++) tbl[i] = 6'b000_001;
    tbl[10] = 6'b010_001;
    tbl[11] = 6'b000_011;
    tbl[12] = 6'b010_000;
    tbl[13] = 6'b101_000;
    tbl[14] = 6'b000_000;
    for (int i = 0; i < 15; i++) begin
      b_ls = tbl[i].ls; b_cd = tbl[i].cd; b_ab = tbl[i].ab;
      chk($sformatf("tbl%0d_cs", i), b_cs, tbl[i].cs);
      chk($sformatf("tbl%0d_ld", i), b_ld, tbl[i].ld);
      chk($sformatf("tbl%0d_busy", i), b_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_gidx", i), b_gidx, 0);
      step();
    end
    b_ls = 0; b_cd = 0; b_ab = 0;

    // four groups, engine answers 700 cycles after each conv_start
    base_cs = a_cs_cnt; base_ld = a_ld_cnt;
    a_ls = 1; step(); a_ls = 0;
    chk("g4_load_busy", a_busy, 1); chk("g4_load_cs", a_cs, 0);
    step();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("g4_start%0d", g), a_cs, 1);
      chk($sformatf("g4_gidx%0d", g), a_gidx, g);
      chk($sformatf("g4_wbase%0d", g), a_wb, g * 9);
      chk($sformatf("g4_obase%0d", g), a_ob, g * 676);
      repeat (699) step();
      chk("g4_run_cs", a_cs, 0); chk("g4_run_busy", a_busy, 1);
      step(); a_cd = 1;
      step(); a_cd = 0;
      if (g < 3) begin
        chk("g4_next_gidx", a_gidx, g);
        step();
        chk("g4_load_gidx", a_gidx, g + 1);
        chk("g4_load_wbase", a_wb, (g + 1) * 9);
        chk("g4_load_obase", a_ob, (g + 1) * 676);
        chk("g4_load_nocs", a_cs, 0);
        step();
      end else begin
        chk("g4_done", a_ld, 1);
        step();
        chk("g4_idle_busy", a_busy, 0); chk("g4_idle_ld", a_ld, 0);
      end
    end
    step();
    chk("g4_start_count", a_cs_cnt - base_cs, 4);
    chk("g4_done_count", a_ld_cnt - base_ld, 1);

    // abort during RUN of group 2
    base_ld = a_ld_cnt;
    a_ls = 1; step(); a_ls = 0; step();
    for (int g = 0; g < 2; g++) begin
      repeat (5) step(); a_cd = 1; step(); a_cd = 0; step(); step();
    end
    chk("ab_start_g2", a_cs, 1); chk("ab_gidx_run", a_gidx, 2);
    repeat (10) step();
    a_ab = 1; step(); a_ab = 0;
    chk("ab_idle_busy", a_busy, 0); chk("ab_gidx_hold", a_gidx, 2);
    chk("ab_wbase_hold", a_wb, 18); chk("ab_obase_hold", a_ob, 1352);
    repeat (20) step();
    chk("ab_no_done", a_ld_cnt - base_ld, 0);

    // watchdog: group 1 never answers
    c_ls = 1; step(); c_ls = 0; step();
    repeat (3) step(); c_cd = 1; step(); c_cd = 0; step(); step();
    chk("to_start_g1", c_cs, 1); chk("to_gidx", c_gidx, 1);
    repeat (TO) step();
    chk("to_last_run_busy", c_busy, 1); chk("to_last_run_terr", c_terr, 0);
    step();
    chk("to_err_busy", c_busy, 0); chk("to_err_terr", c_terr, 1);
    repeat (5) step();
    chk("to_err_hold", c_terr, 1); chk("to_err_gidx", c_gidx, 1);
    c_ls = 1; step(); c_ls = 0;
    chk("to_restart_terr", c_terr, 0); chk("to_restart_gidx", c_gidx, 0);
    chk("to_restart_busy", c_busy, 1); chk("to_restart_wbase", c_wb, 0);
    step();
    chk("to_restart_cs", c_cs, 1);
    c_ab = 1; step(); c_ab = 0;

    // asynchronous reset in the middle of group 1
    a_ls = 1; step(); a_ls = 0; step();
    repeat (3) step(); a_cd = 1; step(); a_cd = 0; step(); step();
    repeat (4) step();
    chk("mr_pre_gidx", a_gidx, 1);
    #3 resetn = 1'b0;
    #1;
    chk("mr_busy", a_busy, 0); chk("mr_cs", a_cs, 0);
    chk("mr_gidx", a_gidx, 0); chk("mr_wbase", a_wb, 0); chk("mr_obase", a_ob, 0);
    #4 resetn = 1'b1;
    step();

    // random layers on the four-group, short-watchdog build
    g0 = 0; t0 = 0;
    for (int s = 0; s < 40; s++) begin
      for (int g = 0; g < NG; g++) begin
        case ($urandom_range(0, 9))
          7:       lat[g] = TO;
          8:       lat[g] = TO + 1;
          9:       lat[g] = $urandom_range(TO + 2, 80);
          default: lat[g] = $urandom_range(1, 40);
        endcase
      end
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 300) : -1;
      build_scen(abort_at, t0, g0, len);
      exp_perf = 0;
`ifdef CONV1_SEQ_PERF_EN
      for (int c = 0; c < len; c++) exp_perf += e_busy[c];
`endif
      for (int c = 0; c < len; c++) begin
        c_ls = drv_ls[c]; c_cd = drv_cd[c]; c_ab = drv_ab[c];
        chk("r_cs", c_cs, e_cs[c]);
        chk("r_ld", c_ld, e_ld[c]);
        chk("r_busy", c_busy, e_busy[c]);
        chk("r_terr", c_terr, e_terr[c]);
        chk("r_gidx", c_gidx, e_gidx[c]);
        chk("r_wbase", c_wb, e_gidx[c] * 9);
        chk("r_obase", c_ob, e_gidx[c] * 676);
        if (c == len - 1) chk("r_perf", c_perf, exp_perf);
        step();
      end
      c_ls = 0; c_cd = 0; c_ab = 0;
      g0 = e_gidx[len-1];
      t0 = e_terr[len-1];
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
